// File: rtl/m_mem_access_ctrl_if.sv
// Data-bus handshake bundle between the M-stage access controller and the bus fabric.
// Rev 1.0 - initial release
`default_nettype none

interface m_mem_access_ctrl_if;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busByteEn;
  logic        busReq;
  logic        busAck;
  logic [31:0] busRData;

  modport master (
    output busAddr, busWData, busByteEn, busReq,
    input  busAck, busRData
  );

  modport slave (
    input  busAddr, busWData, busByteEn, busReq,
    output busAck, busRData
  );
endinterface

`default_nettype wire

// File: rtl/m_mem_access_ctrl.sv
// m_mem_access_ctrl: M-stage load/store alignment check, req/ack bus access with timeout, stall.
// Rev 1.0 - initial release
`default_nettype none

module m_mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        memRead,
  input  wire logic        memWrite,
  input  wire logic [31:0] memAddr,
  input  wire logic [31:0] memWriteData,
  input  wire logic [1:0]  memStoreOp,
  input  wire logic [2:0]  memLoadOp,
  m_mem_access_ctrl_if.master bus,
  output logic             memStall,
  output logic [31:0]      outMemData,
  output logic [1:0]       lowBit,
  output logic [2:0]       outLoadOp,
  output logic             busError,
  output logic             excAdEL,
  output logic             excAdES
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [31:0]      r_busAddr, r_busWData, r_outMemData;
  logic [3:0]       r_busByteEn;
  logic             r_busReq, r_busError, r_isLoad;
  logic [1:0]       r_lowBit;
  logic [2:0]       r_outLoadOp;
  logic [CNT_W-1:0] r_cnt;

  logic        w_aligned, w_reqValid, w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Alignment by access size; reserved encodings fall back to word rules.
  always_comb begin
    w_aligned = 1'b1;
    if (memWrite) begin
      case (memStoreOp)
        2'b01:   w_aligned = ~memAddr[0];
        2'b10:   w_aligned = 1'b1;
        default: w_aligned = (memAddr[1:0] == 2'b00);
      endcase
    end else if (memRead) begin
      case (memLoadOp)
        3'b001:  w_aligned = ~memAddr[0];
        3'b010:  w_aligned = 1'b1;
        default: w_aligned = (memAddr[1:0] == 2'b00);
      endcase
    end
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = memWriteData;
    if (memWrite) begin
      case (memStoreOp)
        2'b01: begin
          w_be    = memAddr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{memWriteData[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b0001 << memAddr[1:0];
          w_wdata = {4{memWriteData[7:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = memWriteData;
        end
      endcase
    end
  end

  assign w_reqValid = memRead | memWrite;
  assign w_accept   = (r_state == S_IDLE) && w_reqValid && w_aligned;

  assign excAdEL  = (r_state == S_IDLE) && memRead  && !w_aligned;
  assign excAdES  = (r_state == S_IDLE) && memWrite && !w_aligned;
  assign memStall = w_accept || (r_state == S_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (bus.busAck || (r_cnt == c_timeout)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busAddr    <= '0;
      r_busWData   <= '0;
      r_busByteEn  <= '0;
      r_busReq     <= 1'b0;
      r_outMemData <= '0;
      r_lowBit     <= '0;
      r_outLoadOp  <= '0;
      r_busError   <= 1'b0;
      r_isLoad     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busAddr   <= {memAddr[31:2], 2'b00};
            r_busWData  <= w_wdata;
            r_busByteEn <= w_be;
            r_busReq    <= 1'b1;
            r_lowBit    <= memAddr[1:0];
            r_outLoadOp <= memLoadOp;
            r_isLoad    <= memRead;
            r_cnt       <= '0;
          end
        end
        S_WAIT: begin
          if (bus.busAck) begin
            if (r_isLoad) r_outMemData <= bus.busRData;
            r_busReq   <= 1'b0;
            r_busError <= 1'b0;
          end else if (r_cnt == c_timeout) begin
            r_busReq     <= 1'b0;
            r_outMemData <= '0;
            r_busError   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busAddr   = r_busAddr;
  assign bus.busWData  = r_busWData;
  assign bus.busByteEn = r_busByteEn;
  assign bus.busReq    = r_busReq;
  assign outMemData    = r_outMemData;
  assign lowBit        = r_lowBit;
  assign outLoadOp     = r_outLoadOp;
  assign busError      = r_busError;

endmodule

`default_nettype wire

// File: tb/tb_m_mem_access_ctrl.sv
// Directed testbench for m_mem_access_ctrl with hand-computed expectations.
// Rev 1.0 - initial release
`default_nettype none

module tb_m_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [31:0] memAddr, memWriteData;
  logic [1:0]  memStoreOp;
  logic [2:0]  memLoadOp;
  logic        memStall, busError, excAdEL, excAdES;
  logic [31:0] outMemData;
  logic [1:0]  lowBit;
  logic [2:0]  outLoadOp;

  int n_checks = 0;
  int n_errors = 0;

  m_mem_access_ctrl_if bus_if ();

  m_mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memStoreOp  (memStoreOp),
    .memLoadOp   (memLoadOp),
    .bus         (bus_if.master),
    .memStall    (memStall),
    .outMemData  (outMemData),
    .lowBit      (lowBit),
    .outLoadOp   (outLoadOp),
    .busError    (busError),
    .excAdEL     (excAdEL),
    .excAdES     (excAdES)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    memRead = 0; memWrite = 0; memAddr = 0; memWriteData = 0;
    memStoreOp = 0; memLoadOp = 0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] op);
    memRead = 1; memWrite = 0; memAddr = a; memLoadOp = op; memStoreOp = 0;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    memRead = 0; memWrite = 1; memAddr = a; memWriteData = d; memStoreOp = op; memLoadOp = 0;
  endtask

  // Request inputs already driven just after a rising edge. Acks on WAIT cycle
  // index ack_dly (-1 = never). Returns at the DONE-cycle negedge.
  task automatic run_access(input int ack_dly, input logic [31:0] rdata, output int stalls,
                            output logic [31:0] f_addr, output logic [31:0] f_wdata,
                            output logic [3:0] f_be);
    int wait_n = 0;
    bit done = 0;
    stalls = 0; f_addr = 0; f_wdata = 0; f_be = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!memStall) begin
        done = 1;
      end else begin
        stalls++;
        if (bus_if.busReq) begin
          if (wait_n == 0) begin
            f_addr = bus_if.busAddr; f_wdata = bus_if.busWData; f_be = bus_if.busByteEn;
          end
          if (wait_n == ack_dly) begin
            bus_if.busAck = 1; bus_if.busRData = rdata;
          end
          wait_n++;
        end
        @(posedge clk); #1;
        bus_if.busAck = 0; bus_if.busRData = 32'h0;
      end
    end
    if (!done) check("access_timeout_bound", 32'd0, 32'd1);
  endtask

  task automatic finish_access();
    @(posedge clk); #1;
    clear_req();
  endtask

  int          st;
  logic [31:0] fa, fw;
  logic [3:0]  fb;

  initial begin
    clear_req();
    bus_if.busAck = 0; bus_if.busRData = 0;
    reset = 1;
    #12;
    check("rst_busReq", {31'b0, bus_if.busReq}, 0);
    check("rst_busAddr", bus_if.busAddr, 0);
    check("rst_outMemData", outMemData, 0);
    check("rst_busError", {31'b0, busError}, 0);
    reset = 0;
    @(posedge clk); #1;

    // lw, ack in first WAIT cycle
    set_load(32'h0000_1004, 3'b000);
    run_access(0, 32'h8765_4321, st, fa, fw, fb);
    check("lw_stall", st, 2);
    check("lw_busAddr", fa, 32'h1004);
    check("lw_be", {28'b0, fb}, 0);
    check("lw_data", outMemData, 32'h8765_4321);
    check("lw_lowBit", {30'b0, lowBit}, 0);
    check("lw_loadOp", {29'b0, outLoadOp}, 0);
    check("lw_busError", {31'b0, busError}, 0);
    check("lw_done_stall", {31'b0, memStall}, 0);
    finish_access();

    // sb / sh replicated data
    set_store(32'h0000_2003, 32'h0000_00A5, 2'b10);
    run_access(0, 32'h1111_1111, st, fa, fw, fb);
    check("sb_be", {28'b0, fb}, 32'b1000);
    check("sb_wdata", fw, 32'hA5A5_A5A5);
    check("sb_addr", fa, 32'h2000);
    check("sb_keeps_rdata", outMemData, 32'h8765_4321);
    finish_access();
    set_store(32'h0000_2002, 32'h1234_BEEF, 2'b01);
    run_access(0, 32'h0, st, fa, fw, fb);
    check("sh_be", {28'b0, fb}, 32'b1100);
    check("sh_wdata", fw, 32'hBEEF_BEEF);
    finish_access();

    // Misaligned accesses
    set_load(32'h0000_3001, 3'b001);
    @(negedge clk);
    check("lh_mis_excAdEL", {31'b0, excAdEL}, 1);
    check("lh_mis_stall", {31'b0, memStall}, 0);
    @(posedge clk); #1;
    check("lh_mis_busReq", {31'b0, bus_if.busReq}, 0);
    set_store(32'h0000_3002, 32'hFFFF_FFFF, 2'b00);
    @(negedge clk);
    check("sw_mis_excAdES", {31'b0, excAdES}, 1);
    check("sw_mis_excAdEL", {31'b0, excAdEL}, 0);
    @(posedge clk); #1;
    check("sw_mis_busReq", {31'b0, bus_if.busReq}, 0);
    clear_req();

    // Spurious ack in IDLE, then lb with delayed ack
    bus_if.busAck = 1; bus_if.busRData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_if.busAck = 0; bus_if.busRData = 0;
    check("spurious_ignored", outMemData, 32'h8765_4321);
    set_load(32'h0000_4002, 3'b010);
    run_access(3, 32'h00CC_0000, st, fa, fw, fb);
    check("lb_stall", st, 5);
    check("lb_data", outMemData, 32'h00CC_0000);
    check("lb_lowBit", {30'b0, lowBit}, 2);
    check("lb_loadOp", {29'b0, outLoadOp}, 3'b010);
    finish_access();

    // Reset during WAIT
    set_load(32'h0000_6000, 3'b000);
    @(posedge clk); #1;
    check("pre_rst_busReq", {31'b0, bus_if.busReq}, 1);
    #2; reset = 1; clear_req();
    #1;
    check("wrst_busReq", {31'b0, bus_if.busReq}, 0);
    check("wrst_outMemData", outMemData, 0);
    check("wrst_lowBit", {30'b0, lowBit}, 0);
    check("wrst_loadOp", {29'b0, outLoadOp}, 0);
    check("wrst_stall", {31'b0, memStall}, 0);
    #2; reset = 0;
    @(posedge clk); #1;
    set_load(32'h0000_7008, 3'b000);
    run_access(0, 32'hCAFE_F00D, st, fa, fw, fb);
    check("post_rst_stall", st, 2);
    check("post_rst_data", outMemData, 32'hCAFE_F00D);
    finish_access();

    // Timeout: no ack ever
    set_load(32'h0000_5000, 3'b000);
    run_access(-1, 32'h0, st, fa, fw, fb);
    check("to_stall", st, 6);
    check("to_busError", {31'b0, busError}, 1);
    check("to_data", outMemData, 0);
    check("to_busReq_done", {31'b0, bus_if.busReq}, 0);
    finish_access();
    @(negedge clk);
    check("to_busReq_after", {31'b0, bus_if.busReq}, 0);
    check("to_busError_hold", {31'b0, busError}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/m_mem_access_ctrl.md
Name: m_mem_access_ctrl

Overview:
- M-stage data-memory access controller. Sits directly upstream of the load-extension stage.
- Takes the M-stage load/store request and checks alignment. Generates byte enables and replicated store data.
- Runs a req/ack handshake with the data bus (DM, timers, bridge), with a timeout.
- Stalls the pipeline until the access completes.
- Hands the raw 32-bit read word, address low bits and load opcode to the extension stage.

Parameters:
TIMEOUT, 255, maximum WAIT cycles without busAck before the access is aborted with busError
CNT_W, 8, counter width; TIMEOUT must be < 2^CNT_W

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
memRead  input  1  M-stage instruction is a load
memWrite  input  1  M-stage instruction is a store; memRead and memWrite are never both 1
memAddr  input  32  byte address
memWriteData  input  32  store source register value
memStoreOp  input  2  00 sw, 01 sh, 10 sb, 11 reserved (treated as sw)
memLoadOp  input  3  000 lw, 001 lh, 010 lb; same encoding the extension stage consumes
busAddr  output  32  word-aligned address {addr[31:2],2'b00}, registered
busWData  output  32  store data, replicated per size, registered
busByteEn  output  4  byte write enables, 0000 for loads, registered
busReq  output  1  request valid, registered
busAck  input  1  single-cycle completion strobe from bus
busRData  input  32  read data, valid when busAck=1
memStall  output  1  freezes F/D/E/M stages
outMemData  output  32  captured raw read word, to extension stage
lowBit  output  2  captured addr[1:0], to extension stage
outLoadOp  output  3  captured memLoadOp, to extension stage
busError  output  1  access terminated by timeout, valid in DONE
excAdEL  output  1  misaligned load, combinational in IDLE
excAdES  output  1  misaligned store, combinational in IDLE

Behaviour:
- Reset (async, immediate): state=IDLE.
  - busReq=0, busByteEn=0, busAddr=0, busWData=0.
  - outMemData=0, lowBit=0, outLoadOp=0, busError=0, counter=0.
- Alignment:
  - Word ops require addr[1:0]=00. Half ops require addr[0]=0. Byte ops are always aligned.
  - Misaligned request in IDLE: excAdEL (load) or excAdES (store)=1, no bus request, memStall=0, state stays IDLE.
- Store data and byte enables:
  - sw: BE=1111, data as-is.
  - sh: BE=addr[1]?1100:0011, data={2{d[15:0]}}.
  - sb: BE=0001<<addr[1:0], data={4{d[7:0]}}.
- State IDLE:
  - If an aligned request is present: memStall=1 combinationally.
  - At the edge, latch busAddr/busWData/busByteEn, lowBit and outLoadOp; set busReq=1, clear counter, go WAIT.
- State WAIT:
  - memStall=1; busReq held at 1; all bus outputs stable.
  - busAck=1: capture busRData into outMemData (loads only; stores leave outMemData unchanged), busReq<=0, busError<=0, go DONE.
  - Else if counter==TIMEOUT: busReq<=0, outMemData<=0, busError<=1, go DONE.
  - Else counter increments.
- State DONE:
  - memStall=0; the instruction leaves M at this edge. Request inputs are ignored (same instruction). Next state is IDLE.
  - outMemData, lowBit, outLoadOp and busError hold their values until the next capture.
- Minimum latency: 2 stall cycles (accept + ack in first WAIT cycle); results are valid in the DONE cycle.
- busAck is ignored outside WAIT.
- Reset in WAIT aborts the transaction: busReq drops asynchronously and no capture occurs.
- outMemData and lowBit are registered, so the extension stage sees stable inputs in DONE and the following cycles.

Test Plan:
- lw addr=0x0000_1004, busAck in first WAIT cycle with busRData=0x8765_4321 -> memStall high for exactly 2 cycles; busAddr=0x1004, BE=0000; in DONE outMemData=0x8765_4321, lowBit=00, outLoadOp=000, busError=0.
- sb addr=0x2003, memWriteData=0x0000_00A5 -> busByteEn=1000, busWData=0xA5A5_A5A5; sh addr=0x2002, data=0x1234BEEF -> BE=1100, busWData=0xBEEF_BEEF.
- lh addr=0x3001 -> excAdEL=1, busReq stays 0, memStall=0; sw addr=0x3002 -> excAdES=1, no request.
- TIMEOUT=4, load with busAck never asserted -> memStall for 6 cycles total; DONE with busError=1, outMemData=0; busReq low from DONE onward.
- lb addr=0x4002, busAck delayed 3 WAIT cycles, spurious busAck pulse in IDLE beforehand -> pulse ignored; outMemData captured only at the real ack; lowBit=10, outLoadOp=010.
- Assert reset during WAIT -> busReq=0 and all outputs 0 immediately; after release, a new lw completes normally.
